// File: rtl/button_debouncer.sv
// button_debouncer: per-channel two-flop synchronizer followed by a
// consecutive-cycle debounce filter with a registered output level.
module button_debouncer #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] button_sync,
    output logic [NUM_BTN-1:0] bouncing
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] s1_q;
    logic [NUM_BTN-1:0] s2_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          stable_q;
        logic          stable_d;

        // Any cycle of agreement drops the count back to zero.
        always_comb begin
            cnt_d    = '0;
            stable_d = stable_q;
            if (s2_q[i] != stable_q) begin
                if (cnt_q == CNT_LAST) begin
                    stable_d = s2_q[i];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                stable_q <= stable_d;
            end
        end

        assign button_sync[i] = stable_q;
        assign bouncing[i]    = (cnt_q != '0);
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed per-edge vectors for the debouncer
// with NUM_BTN=2 and DEBOUNCE_CYCLES=4.
module tb_button_debouncer;

    logic       clk;
    logic       nrst;
    logic [1:0] btn_raw;
    logic [1:0] button_sync;
    logic [1:0] bouncing;

    int n_chk;
    int n_bad;

    button_debouncer #(
        .NUM_BTN        (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .btn_raw    (btn_raw),
        .button_sync(button_sync),
        .bouncing   (bouncing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] got,
                       input logic [1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%b want=%b", tag, got, exp);
        end
    endtask

    // Drive raw for the coming edge, then sample 1 time unit after it.
    task automatic step(input string tag, input logic [1:0] raw,
                        input logic [1:0] es, input logic [1:0] eb);
        btn_raw = raw;
        @(posedge clk);
        #1;
        chk({tag, " sync"}, button_sync, es);
        chk({tag, " bnc"}, bouncing, eb);
    endtask

    task automatic run(input string tag, input logic [1:0] raw,
                       input logic [1:0] es[], input logic [1:0] eb[]);
        for (int k = 0; k < es.size(); k++)
            step($sformatf("%s e%0d", tag, k + 1), raw, es[k], eb[k]);
    endtask

    logic [1:0] bnc_raw[11];
    logic [1:0] bnc_es[11];
    logic [1:0] bnc_eb[11];

    initial begin
        n_chk   = 0;
        n_bad   = 0;
        nrst    = 1'b0;
        btn_raw = 2'b11;

        // Reset holds everything low even with both pins high.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst e%0d sync", k), button_sync, 2'b00);
            chk($sformatf("rst e%0d bnc", k), bouncing, 2'b00);
        end
        btn_raw = 2'b00;
        #2;
        nrst = 1'b1;
        for (int k = 0; k < 2; k++)
            step($sformatf("idle e%0d", k), 2'b00, 2'b00, 2'b00);

        // Press channel 0: rises on edge 6, bouncing on edges 3-5.
        run("press0", 2'b01,
            '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01},
            '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00});

        // Release channel 0: falls on edge 6.
        run("rel0", 2'b00,
            '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00},
            '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00});

        // Three-cycle glitch is rejected; count peaks then clears.
        run("glitch hi", 2'b01,
            '{2'b00, 2'b00, 2'b00},
            '{2'b00, 2'b00, 2'b01});
        run("glitch lo", 2'b00,
            '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00},
            '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00});

        // Bounce train 1,0,1,1,0,1,1,1,1 then held high.
        bnc_raw = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01,
                    2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        bnc_es  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                    2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        bnc_eb  = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01,
                    2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
        for (int k = 0; k < 11; k++)
            step($sformatf("bounce e%0d", k + 1), bnc_raw[k],
                 bnc_es[k], bnc_eb[k]);

        run("rel0b", 2'b00,
            '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00},
            '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00});

        // Reset mid-count discards the partial count.
        run("precnt", 2'b01,
            '{2'b00, 2'b00, 2'b00, 2'b00},
            '{2'b00, 2'b00, 2'b01, 2'b01});
        nrst = 1'b0;
        #1;
        chk("midrst async sync", button_sync, 2'b00);
        chk("midrst async bnc", bouncing, 2'b00);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("midrst e%0d sync", k), button_sync, 2'b00);
            chk($sformatf("midrst e%0d bnc", k), bouncing, 2'b00);
        end
        nrst = 1'b1;
        run("postrst", 2'b01,
            '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01},
            '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00});

        // Channel 1 press while channel 0 stays high.
        run("press1", 2'b11,
            '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11},
            '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00});

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter: NUM_BTN, 4, number of independent button channels (>=1).
REQ-002 SHALL have parameter: DEBOUNCE_CYCLES, 16, consecutive disagreeing clock cycles required to accept a new level (>=1).
REQ-003 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-004 SHALL have port: nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: btn_raw  input  NUM_BTN  raw asynchronous button pins, may bounce or glitch.
REQ-006 SHALL have port: button_sync  output  NUM_BTN  synchronized, debounced level per channel; feeds the downstream edge-detect stage.
REQ-007 SHALL have port: bouncing  output  NUM_BTN  high while the channel's debounce counter is non-zero.

Function
REQ-008 SHALL process every channel independently, with identical logic and no shared state.
REQ-009 SHALL pass each btn_raw bit through a two-flop synchronizer (s1 <= btn_raw, s2 <= s1); only s2 is used downstream.
REQ-010 SHALL hold a per-channel stable register driving button_sync directly (registered output, no combinational path from btn_raw).
REQ-011 SHALL hold a per-channel counter of width $clog2(DEBOUNCE_CYCLES+1) bits.
REQ-012 SHALL, on each edge where s2 == stable, clear the counter to 0 and leave stable unchanged.
REQ-013 SHALL, on each edge where s2 != stable and counter < DEBOUNCE_CYCLES-1, increment the counter by 1.
REQ-014 SHALL, on the edge where s2 != stable and counter == DEBOUNCE_CYCLES-1, load stable <= s2 and clear the counter to 0 in the same edge.
REQ-015 SHALL never let the counter exceed DEBOUNCE_CYCLES-1 and never let it wrap.
REQ-016 SHALL drive bouncing[i] = (counter[i] != 0), combinationally from the registered counter.
REQ-017 SHALL give a latency of exactly DEBOUNCE_CYCLES+2 rising edges from the first edge sampling a new, held btn_raw level to button_sync showing that level (2 synchronizer + DEBOUNCE_CYCLES filter).
REQ-018 SHALL reject any s2 excursion shorter than DEBOUNCE_CYCLES consecutive cycles: the counter returns to 0 and button_sync does not change.
REQ-019 SHALL restart the count from 0 whenever s2 returns to stable for even one cycle, so bounce trains only qualify once the level holds continuously.
REQ-020 SHALL treat press (0->1) and release (1->0) symmetrically.
REQ-021 SHALL, with DEBOUNCE_CYCLES == 1, accept a new level on the first disagreeing edge; bouncing then stays 0.

Reset
REQ-022 SHALL, while nrst is low, asynchronously force s1, s2, stable, and counter of every channel to 0, so button_sync = 0 and bouncing = 0.
REQ-023 SHALL, on reset asserted mid-count, discard the partial count; after release, a held-high input needs the full DEBOUNCE_CYCLES+2 edges again.
REQ-024 SHALL resume normal operation on the first rising clk edge after nrst deasserts.

Verification (NUM_BTN=2, DEBOUNCE_CYCLES=4)
REQ-025 SHALL cover: nrst low with btn_raw=2'b11 -> button_sync=2'b00, bouncing=2'b00 throughout reset.
REQ-026 SHALL cover: btn_raw[0] 0->1 held -> button_sync[0] rises on the 6th edge; bouncing[0] high for edges 3-5 only; channel 1 unaffected.
REQ-027 SHALL cover: btn_raw[0] high for 3 cycles, then low -> button_sync[0] stays 0; counter peaks at 3, then returns to 0.
REQ-028 SHALL cover: bounce pattern 1,0,1,1,0,1,1,1,1 then held -> button_sync[0] rises only after 4 consecutive high s2 cycles, 6 edges after the final rising transition.
REQ-029 SHALL cover: with button_sync[0]=1, btn_raw[0] 1->0 held -> button_sync[0] falls on the 6th edge.
REQ-030 SHALL cover: nrst pulsed low when counter=2 -> outputs 0 immediately; after release, input held high rises again after the full 6 edges.
